// File: rtl/armleo_mem_pkg.sv
// Shared definitions for the armleo_mem family of RAM cells.
//   mem_state_t : controller state (zeroing sweep / accepting traffic)
//   mask_width  : number of byte-enable bits for a given data/byte width
package armleo_mem_pkg;

    typedef enum logic {
        MEM_INIT,
        MEM_READY
    } mem_state_t;

    function automatic int unsigned mask_width(input int unsigned width,
                                               input int unsigned byte_width);
        return width / byte_width;
    endfunction

endpackage

// File: rtl/armleo_mem_rdport.sv
// One synchronous read port of armleo_mem_nr1w.
//   clk, rst    : clock, async active-high reset (clears read_data)
//   read        : read enable, already qualified by the cell's ready state
//   read_addr   : address being read
//   mem_data    : current (pre-write) storage content at read_addr
//   write*      : write port of the cell, qualified by ready, for the bypass merge
//   read_data   : registered read result, held while read is low
module armleo_mem_rdport
    import armleo_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned BYPASS     = 0,
    localparam int unsigned MASK_W    = mask_width(WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic [DEPTH_LOG2-1:0] read_addr,
    input  logic [WIDTH-1:0]      mem_data,
    input  logic                  write,
    input  logic [DEPTH_LOG2-1:0] write_addr,
    input  logic [MASK_W-1:0]     write_mask,
    input  logic [WIDTH-1:0]      write_data,
    output logic [WIDTH-1:0]      read_data
);

    logic [WIDTH-1:0] read_data_q, read_data_d;
    logic [WIDTH-1:0] merged;
    logic             hit;

    always_comb begin
        // Write-first view of the addressed word: new bytes where masked, old elsewhere
        merged = mem_data;
        for (int b = 0; b < int'(MASK_W); b++) begin
            if (write_mask[b]) begin
                merged[b*BYTE_WIDTH +: BYTE_WIDTH] = write_data[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        hit = (BYPASS != 0) && write && (write_addr == read_addr);

        read_data_d = read_data_q;
        if (read) begin
            read_data_d = hit ? merged : mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: rtl/armleo_mem_nr1w.sv
// Block RAM cell: READ_PORTS synchronous read ports, one byte-masked write port,
// selectable read-during-write behaviour and optional zeroing sweep after reset.
//   clk, rst   : clock, async active-high reset
//   ready      : high when reads/writes are accepted
//   read       : per-port read enables
//   read_addr  : packed read addresses, port i at [i*DEPTH_LOG2 +: DEPTH_LOG2]
//   read_data  : packed registered read data, port i at [i*WIDTH +: WIDTH]
//   write, write_addr, write_mask, write_data : write port, mask bit b covers byte b
module armleo_mem_nr1w
    import armleo_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned READ_PORTS = 2,
    parameter int unsigned BYPASS     = 0,
    parameter int unsigned INIT_ZERO  = 1,
    localparam int unsigned MASK_W    = mask_width(WIDTH, BYTE_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             ready,
    input  logic [READ_PORTS-1:0]            read,
    input  logic [READ_PORTS*DEPTH_LOG2-1:0] read_addr,
    output logic [READ_PORTS*WIDTH-1:0]      read_data,
    input  logic                             write,
    input  logic [DEPTH_LOG2-1:0]            write_addr,
    input  logic [MASK_W-1:0]                write_mask,
    input  logic [WIDTH-1:0]                 write_data
);

    localparam int unsigned ELEMENTS = 1 << DEPTH_LOG2;

    if (WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("armleo_mem_nr1w: WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_PORTS < 1) begin : g_bad_ports
        $error("armleo_mem_nr1w: READ_PORTS must be at least 1");
    end

    logic [WIDTH-1:0] storage [ELEMENTS];

    mem_state_t            state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic                  init_we;
    logic                  wr_en;
    logic [READ_PORTS-1:0] rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (INIT_ZERO != 0) begin
                state_q <= MEM_INIT;
            end else begin
                state_q <= MEM_READY;
            end
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            MEM_INIT: begin
                init_we = 1'b1;
                if (cnt_q == '1) begin
                    state_d = MEM_READY;
                end else begin
                    cnt_d = cnt_q + DEPTH_LOG2'(1);
                end
            end
            default: ;
        endcase
    end

    // ready decodes a register, so there is no input-to-output path
    assign ready = (state_q == MEM_READY);
    assign wr_en = ready && write;
    assign rd_en = read & {READ_PORTS{ready}};

    // Contents are deliberately not reset; only the sweep clears them
    always_ff @(posedge clk) begin
        if (init_we) begin
            storage[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (write_mask[b]) begin
                    storage[write_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                        write_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    for (genvar i = 0; i < int'(READ_PORTS); i++) begin : g_rd
        armleo_mem_rdport #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .WIDTH      (WIDTH),
            .BYTE_WIDTH (BYTE_WIDTH),
            .BYPASS     (BYPASS)
        ) u_rdport (
            .clk        (clk),
            .rst        (rst),
            .read       (rd_en[i]),
            .read_addr  (read_addr[i*DEPTH_LOG2 +: DEPTH_LOG2]),
            .mem_data   (storage[read_addr[i*DEPTH_LOG2 +: DEPTH_LOG2]]),
            .write      (wr_en),
            .write_addr (write_addr),
            .write_mask (write_mask),
            .write_data (write_data),
            .read_data  (read_data[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_armleo_mem_nr1w.sv
// Bench for armleo_mem_nr1w: one read-first and one write-first instance share
// the same stimulus and are checked against a word-array reference model.
module tb_armleo_mem_nr1w;

    localparam int DL = 5;
    localparam int N  = 1 << DL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rd  = '0;
    logic [4:0]  ra0 = '0, ra1 = '0;
    logic        wr  = 1'b0;
    logic [4:0]  wa  = '0;
    logic [3:0]  wm  = '0;
    logic [31:0] wd  = '0;

    logic        ready0, ready1;
    logic [63:0] rdata0, rdata1;

    always #5 clk = ~clk;

    armleo_mem_nr1w #(.BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0), .read(rd), .read_addr({ra1, ra0}),
        .read_data(rdata0), .write(wr), .write_addr(wa), .write_mask(wm), .write_data(wd)
    );
    armleo_mem_nr1w #(.BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .ready(ready1), .read(rd), .read_addr({ra1, ra0}),
        .read_data(rdata1), .write(wr), .write_addr(wa), .write_mask(wm), .write_data(wd)
    );

    // Reference model: memory words, ready flag, sweep position, expected read data
    logic [31:0] m_mem [N];
    logic        m_ready;
    int          m_cnt;
    logic [31:0] m_exp [2][2];  // [bypass][port]

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w,
                                          logic [3:0] mask);
        logic [31:0] r = old_w;
        for (int b = 0; b < 4; b++) if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_cnt   = 0;
        for (int b = 0; b < 2; b++) for (int p = 0; p < 2; p++) m_exp[b][p] = '0;
    endtask

    task automatic model_step();
        logic [4:0] a;
        if (!m_ready) begin
            m_mem[m_cnt] = '0;
            if (m_cnt == N - 1) m_ready = 1'b1;
            m_cnt++;
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = (p == 0) ? ra0 : ra1;
                if (rd[p]) begin
                    m_exp[0][p] = m_mem[a];
                    m_exp[1][p] = (wr && wa == a) ? merge(m_mem[a], wd, wm) : m_mem[a];
                end
            end
            if (wr) m_mem[wa] = merge(m_mem[wa], wd, wm);
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, " ready bp0"}, {31'b0, ready0}, {31'b0, m_ready});
        chk({tag, " ready bp1"}, {31'b0, ready1}, {31'b0, m_ready});
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s bp0 port%0d", tag, p), rdata0[p*32 +: 32], m_exp[0][p]);
            chk($sformatf("%s bp1 port%0d", tag, p), rdata1[p*32 +: 32], m_exp[1][p]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, " ready0"}, {31'b0, ready0}, 32'd0);
        chk({tag, " ready1"}, {31'b0, ready1}, 32'd0);
        chk({tag, " rdata0 lo"}, rdata0[31:0], 32'd0);
        chk({tag, " rdata0 hi"}, rdata0[63:32], 32'd0);
        chk({tag, " rdata1 lo"}, rdata1[31:0], 32'd0);
        chk({tag, " rdata1 hi"}, rdata1[63:32], 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  wa;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic [1:0]  rd;
        logic [4:0]  ra0, ra1;
        logic [31:0] e00, e01, e10, e11;  // e<bypass><port>
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  4'h0, 32'h0,        2'b11, 5'd3,  5'd31,
                     32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 5'd3,  4'hF, 32'hAABBCCDD, 2'b00, 5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, 5'd3,  4'h5, 32'h11223344, 2'b00, 5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  4'h0, 32'h0,        2'b01, 5'd3,  5'd0,
                     32'hAA22CC44, 32'h0, 32'hAA22CC44, 32'h0};
        vecs[4]  = '{1'b1, 5'd7,  4'hF, 32'h00000005, 2'b00, 5'd0,  5'd0,
                     32'hAA22CC44, 32'h0, 32'hAA22CC44, 32'h0};
        vecs[5]  = '{1'b1, 5'd7,  4'h3, 32'hFFFFFFFF, 2'b01, 5'd7,  5'd0,
                     32'h00000005, 32'h0, 32'h0000FFFF, 32'h0};
        vecs[6]  = '{1'b0, 5'd0,  4'h0, 32'h0,        2'b01, 5'd7,  5'd0,
                     32'h0000FFFF, 32'h0, 32'h0000FFFF, 32'h0};
        vecs[7]  = '{1'b1, 5'd1,  4'hF, 32'hCAFEBABE, 2'b00, 5'd0,  5'd0,
                     32'h0000FFFF, 32'h0, 32'h0000FFFF, 32'h0};
        vecs[8]  = '{1'b1, 5'd31, 4'hF, 32'hDEADBEEF, 2'b00, 5'd0,  5'd0,
                     32'h0000FFFF, 32'h0, 32'h0000FFFF, 32'h0};
        vecs[9]  = '{1'b0, 5'd0,  4'h0, 32'h0,        2'b11, 5'd1,  5'd31,
                     32'hCAFEBABE, 32'hDEADBEEF, 32'hCAFEBABE, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 5'd0,  4'h0, 32'h0,        2'b11, 5'd31, 5'd31,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 5'd31, 4'h0, 32'h0,        2'b00, 5'd0,  5'd0,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 5'd0,  4'h0, 32'h0,        2'b01, 5'd31, 5'd0,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[13] = '{1'b1, 5'd1,  4'h8, 32'h0,        2'b10, 5'd0,  5'd1,
                     32'hDEADBEEF, 32'hCAFEBABE, 32'hDEADBEEF, 32'h00FEBABE};

        // Reset state
        model_reset();
        #1;
        check_reset_values("reset");
        tick();
        tick();
        rst = 1'b0;

        // Zeroing sweep with reads requested on both ports every cycle
        for (int k = 1; k <= N; k++) begin
            rd  = 2'b11;
            ra0 = 5'($urandom_range(0, N - 1));
            ra1 = 5'($urandom_range(0, N - 1));
            wr  = 1'b1;
            wa  = 5'($urandom_range(0, N - 1));
            wm  = 4'hF;
            wd  = $urandom;
            tick();
            chk($sformatf("sweep ready edge %0d", k), {31'b0, ready0}, {31'b0, k == N});
            check_all("sweep");
        end

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            wr = vecs[i].wr; wa = vecs[i].wa; wm = vecs[i].wm; wd = vecs[i].wd;
            rd = vecs[i].rd; ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
            tick();
            chk($sformatf("vec%0d bp0 p0", i), rdata0[31:0],  vecs[i].e00);
            chk($sformatf("vec%0d bp0 p1", i), rdata0[63:32], vecs[i].e01);
            chk($sformatf("vec%0d bp1 p0", i), rdata1[31:0],  vecs[i].e10);
            chk($sformatf("vec%0d bp1 p1", i), rdata1[63:32], vecs[i].e11);
            check_all("vec");
        end

        // Hold: port 1 keeps its data while disabled and the word is overwritten
        wr = 1'b1; wa = 5'd2; wm = 4'hF; wd = 32'h12345678; rd = 2'b00;
        tick();
        wr = 1'b0; rd = 2'b10; ra1 = 5'd2;
        tick();
        chk("hold first read bp0", rdata0[63:32], 32'h12345678);
        chk("hold first read bp1", rdata1[63:32], 32'h12345678);
        for (int k = 0; k < 10; k++) begin
            wr = 1'b1; wa = 5'd2; wm = 4'hF; wd = 32'h0; rd = 2'b01; ra0 = 5'd2;
            tick();
            chk("hold bp0 port1", rdata0[63:32], 32'h12345678);
            chk("hold bp1 port1", rdata1[63:32], 32'h12345678);
            check_all("hold");
        end

        // Random traffic on a narrow address range to provoke collisions
        for (int k = 0; k < 400; k++) begin
            wr  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 7));
            wm  = 4'($urandom);
            wd  = $urandom;
            rd  = 2'($urandom);
            ra0 = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            tick();
            check_all("random");
        end

        // Reset during traffic, then again in the middle of the sweep
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_values("rst traffic");
        tick();
        rst = 1'b0;
        rd = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_all("sweep a");
        end
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_values("rst sweep");
        tick();
        rst = 1'b0;
        for (int k = 1; k <= N; k++) begin
            wr  = 1'b1;
            wa  = 5'($urandom_range(0, N - 1));
            wm  = 4'hF;
            wd  = $urandom | 32'h1;
            rd  = 2'b11;
            ra0 = 5'($urandom_range(0, N - 1));
            ra1 = 5'($urandom_range(0, N - 1));
            tick();
            chk($sformatf("resweep ready edge %0d", k), {31'b0, ready1}, {31'b0, k == N});
            check_all("sweep b");
        end

        // Every entry reads back zero: writes during the sweep must not have landed
        wr = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd = 2'b11; ra0 = 5'(i); ra1 = 5'(N - 1 - i);
            tick();
            chk($sformatf("zero addr %0d bp0", i), rdata0[31:0], 32'h0);
            chk($sformatf("zero addr %0d bp1", N - 1 - i), rdata1[63:32], 32'h0);
            check_all("zero");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/armleo_mem_nr1w.md
# armleo_mem_nr1w

Parametrised Block RAM cell with N synchronous read ports and one synchronous byte-masked write port, successor to the single-read/single-write cell. Adds selectable read-during-write mode (read-first or write-first bypass), per-byte write mask and an optional post-reset zero-initialisation sweep with a `ready` flag. Targets register files (2R1W / 3R1W), TLB/tag arrays and cache data arrays that need a known content after reset.

## Interface
- DEPTH_LOG2, 5, address width; ELEMENTS = 2**DEPTH_LOG2 entries
- WIDTH, 32, data width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, write-mask granularity; MASK_W = WIDTH/BYTE_WIDTH
- READ_PORTS, 2, number of independent read ports (≥1)
- BYPASS, 0, 0 = read-first (old data on same-address read/write), 1 = write-first (merged new data)
- INIT_ZERO, 1, 1 = zero every entry after reset before accepting traffic; 0 = `ready` high immediately after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ready  out  1  high when reads/writes are accepted
- read  in  READ_PORTS  per-port read enable
- read_addr  in  READ_PORTS*DEPTH_LOG2  packed, port i at [i*DEPTH_LOG2 +: DEPTH_LOG2]
- read_data  out  READ_PORTS*WIDTH  packed, port i at [i*WIDTH +: WIDTH]
- write  in  1  write enable
- write_addr  in  DEPTH_LOG2  write address
- write_mask  in  MASK_W  byte enables, bit b covers [b*BYTE_WIDTH +: BYTE_WIDTH]
- write_data  in  WIDTH  write data

## Operation
- States: INIT, READY. rst asserted → state INIT (INIT_ZERO=1) or READY (INIT_ZERO=0); init counter = 0; all read_data = 0; ready = 0 (INIT_ZERO=1) / 1 (INIT_ZERO=0).
- INIT: each clock writes all-zero to storage[counter], counter += 1; when counter == ELEMENTS-1 is written, state → READY, ready → 1. Counter does not wrap; it is unused in READY.
- INIT: external read/write ignored; read_data holds 0; no writes from ports reach storage.
- READY write: if write, for each b with write_mask[b]=1, storage[write_addr] byte b ← write_data byte b; other bytes unchanged. write_mask = 0 → no change.
- READY read, port i: if read[i], read_data[i] ← storage[read_addr[i]]; else read_data[i] holds its previous value indefinitely.
- Same-cycle read and write to same address, BYPASS=0: read_data gets pre-write content. BYPASS=1: masked bytes from write_data, unmasked bytes from storage.
- Multiple ports may read the same address in the same cycle; all receive identical data.
- rst mid-INIT or mid-traffic: immediately returns to reset values; INIT restarts from address 0; storage content is not reset except by the sweep.

## Timing
- Read latency 1 cycle: addr/enable sampled at edge k, data valid after edge k, held until next enabled read.
- Write visible to a read issued at edge k+1 (or at edge k with BYPASS=1).
- INIT_ZERO=1: after rst deasserts, edge 1 clears address 0, edge n clears address n-1; ready rises after edge ELEMENTS. Traffic is accepted from edge ELEMENTS+1.
- ready is registered; no combinational path from inputs to any output.

## Structure
- Shared package armleo_mem_pkg: state enum (MEM_INIT, MEM_READY) and a function computing MASK_W; elaboration checks for WIDTH % BYTE_WIDTH == 0 and READ_PORTS ≥ 1.
- Storage as a single reg array with byte-granular write loop so synthesis infers BRAM with byte enables.
- Sub-module armleo_mem_rdport: one per read port via generate; holds read_data register and BYPASS merge logic.

## Test plan
- Reset sweep, DEPTH_LOG2=5, INIT_ZERO=1: pulse rst, issue read on all ports each cycle → ready low for 32 edges, read_data = 0; first read after ready of any address returns 0.
- Masked write: write addr 3 data 0xAABBCCDD mask 4'b1111, then addr 3 data 0x11223344 mask 4'b0101, read addr 3 → 0xAA22CC44.
- Collision, addr 7 holding 0x00000005, write 0xFFFFFFFF mask 4'b0011 and read port 0 addr 7 same edge → BYPASS=0: 0x00000005; BYPASS=1: 0x0000FFFF.
- Hold: read port 1 addr 2 (0x12345678), then read[1]=0 for 10 cycles while writing addr 2 = 0 → read_data[1] stays 0x12345678.
- Dual port: port 0 addr 1, port 1 addr 31, same edge, different contents → each returns its own entry; same address on both → identical data.
- Reset mid-sweep at edge 10: rst asserted → ready 0, read_data 0; after deassert, ready rises exactly 32 edges later; writes during INIT are not retained.
